// File: rtl/de2_115_web_qsys_cpu_ocimem_arbiter.sv
// Shares the single port of the OCI debug RAM between JTAG debug commands and the
// CPU's Avalon slave; conflicts are resolved round-robin.
module de2_115_web_qsys_cpu_ocimem_arbiter #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [37:0]       jdo,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic              avs_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [31:0]       MonDReg,
    output logic              jtag_done,
    output logic              jtag_err
);

    typedef enum logic [1:0] {StIdle, StJRdWait, StCRdWait} state_e;

    localparam logic GrantCpu  = 1'b0;
    localparam logic GrantJtag = 1'b1;

    state_e            state_q, state_d;
    logic              j_pend_q, j_pend_d;
    logic              j_isrd_q, j_isrd_d;
    logic [ADDR_W-1:0] j_addr_q, j_addr_d;
    logic [31:0]       j_wdata_q, j_wdata_d;
    logic              last_grant_q, last_grant_d;
    logic [31:0]       mon_q, mon_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              cpu_req, grant_cpu, grant_jtag, j_retire;
    logic              unused_jdo;

    assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

    // Gated by reset so the Avalon and RAM outputs stay idle while reset is held.
    assign cpu_req = reset_n & (avs_read | avs_write);

    always_comb begin
        state_d         = state_q;
        j_pend_d        = j_pend_q;
        j_isrd_d        = j_isrd_q;
        j_addr_d        = j_addr_q;
        j_wdata_d       = j_wdata_q;
        last_grant_d    = last_grant_q;
        mon_d           = mon_q;
        err_d           = err_q;
        grant_cpu       = 1'b0;
        grant_jtag      = 1'b0;
        j_retire        = 1'b0;
        ram_addr        = '0;
        ram_wren        = 1'b0;
        ram_wdata       = '0;
        avs_readdata    = '0;
        avs_waitrequest = cpu_req;

        unique case (state_q)
            StIdle: begin
                grant_cpu  = cpu_req && (!j_pend_q || last_grant_q == GrantJtag);
                grant_jtag = j_pend_q && !grant_cpu;
                if (grant_cpu) begin
                    last_grant_d = GrantCpu;
                    ram_addr     = avs_address;
                    if (avs_write) begin
                        ram_wren        = 1'b1;
                        ram_wdata       = avs_writedata;
                        avs_waitrequest = 1'b0;
                    end else begin
                        state_d = StCRdWait;
                    end
                end else if (grant_jtag) begin
                    last_grant_d = GrantJtag;
                    ram_addr     = j_addr_q;
                    if (j_isrd_q) begin
                        state_d = StJRdWait;
                    end else begin
                        ram_wren  = 1'b1;
                        ram_wdata = j_wdata_q;
                        j_retire  = 1'b1;
                    end
                end
            end
            StJRdWait: begin
                mon_d    = ram_rdata;
                j_retire = 1'b1;
                state_d  = StIdle;
            end
            StCRdWait: begin
                avs_readdata    = ram_rdata;
                avs_waitrequest = 1'b0;
                state_d         = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (j_retire) begin
            j_pend_d = 1'b0;
            j_addr_d = j_addr_q + ADDR_W'(1);
        end
        done_d = j_retire;

        // Intake only while nothing is pending, so it never collides with a retire.
        if (take_action_ocimem_a || take_action_ocimem_b) begin
            if (j_pend_q) begin
                err_d = 1'b1;
            end else if (take_action_ocimem_a) begin
                j_addr_d = jdo[17 +: ADDR_W];
                err_d    = take_action_ocimem_b;
                if (jdo[35]) begin
                    j_pend_d = 1'b1;
                    j_isrd_d = 1'b1;
                end
            end else begin
                j_wdata_d = jdo[34:3];
                j_isrd_d  = 1'b0;
                j_pend_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            j_pend_q     <= 1'b0;
            j_isrd_q     <= 1'b0;
            j_addr_q     <= '0;
            j_wdata_q    <= '0;
            last_grant_q <= GrantJtag;
            mon_q        <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            j_pend_q     <= j_pend_d;
            j_isrd_q     <= j_isrd_d;
            j_addr_q     <= j_addr_d;
            j_wdata_q    <= j_wdata_d;
            last_grant_q <= last_grant_d;
            mon_q        <= mon_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign MonDReg   = mon_q;
    assign jtag_done = done_q;
    assign jtag_err  = err_q;

endmodule
